// File: rtl/swivm_memseq_pkg.sv
// Shared constants for the memory sequencer: FSM states, MMU commands, size and error codes.
package swivm_memseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] MMU_READ  = 4'h1;
  localparam logic [3:0] MMU_WRITE = 4'h2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_BAD  = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [3:0] ERR_NONE     = 4'h0;
  localparam logic [3:0] ERR_MISALIGN = 4'hE;
  localparam logic [3:0] ERR_TIMEOUT  = 4'hF;

  typedef struct packed {
    logic       fault;
    logic [3:0] err;
  } rsp_status_t;

  // Size code 01 has no legal alignment, so it always faults.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BAD:  return 1'b1;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/swivm_rr_arb.sv
// Round-robin arbiter: one-hot grant searching from the channel after the last winner.
module swivm_rr_arb #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NREQ-1:0]  i_req,
  input  logic             i_en,
  output logic [NREQ-1:0]  o_grant_c,
  output logic [IDX_W-1:0] o_idx_c
);

  logic [IDX_W-1:0] last_q;
  logic             found;
  int unsigned      cand;

  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(last_q) + i) % NREQ;
      if (!found && i_req[IDX_W'(cand)]) begin
        found                    = 1'b1;
        o_grant_c[IDX_W'(cand)] = 1'b1;
        o_idx_c                  = IDX_W'(cand);
      end
    end
  end

  // Reset to the top channel so channel 0 wins first.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      last_q <= IDX_W'(NREQ - 1);
    else if (i_en && (|i_req))
      last_q <= o_idx_c;
  end

endmodule

// File: rtl/swivm_memseq.sv
// Multi-channel memory access sequencer in front of an MMU command port.
// Define SWIVM_MEMSEQ_TIMEOUT_EN to bound WAIT at TIMEOUT cycles.
module swivm_memseq
  import swivm_memseq_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ-1:0]          i_req_write,
  input  logic [NREQ-1:0]          i_req_signed,
  input  logic [2*NREQ-1:0]        i_req_size,
  input  logic [ADDR_W*NREQ-1:0]   i_req_addr,
  input  logic [DATA_W*NREQ-1:0]   i_req_wdata,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [NREQ-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_data,
  output logic                     o_rsp_fault,
  output logic [3:0]               o_rsp_err,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [DATA_W-1:0]        o_wrdata,
  output logic [1:0]               o_size,
  output logic [3:0]               o_mmu_cmd,
  output logic                     o_mmu_validcmd,
  input  logic [DATA_W-1:0]        i_rddata,
  input  logic                     i_rddata_valid,
  input  logic [3:0]               i_mmu_error
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     arb_grant_c;
  logic [IDX_W-1:0]    arb_idx_c;
  logic                arb_en_c;

  logic [IDX_W-1:0]    ch_q, ch_d;
  logic                write_q, write_d;
  logic                signed_q, signed_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  rsp_status_t         pend_q, pend_d;

  logic [NREQ-1:0]     ready_d, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_d, wrdata_d;
  logic                rsp_fault_d, validcmd_d;
  logic [3:0]          rsp_err_d, cmd_d;
  logic [ADDR_W-1:0]   oaddr_d;
  logic [1:0]          osize_d;

`ifdef SWIVM_MEMSEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  swivm_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     (i_req_valid),
    .i_en      (arb_en_c),
    .o_grant_c (arb_grant_c),
    .o_idx_c   (arb_idx_c)
  );

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] sz, input logic sgn);
    case (sz)
      SZ_BYTE: return {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
      SZ_HALF: return {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, latched request, pending response and registered output values.
  always_comb begin
    state_d     = state_q;
    arb_en_c    = 1'b0;
    ch_d        = ch_q;
    write_d     = write_q;
    signed_d    = signed_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    rsp_data_d  = o_rsp_data;
    rsp_fault_d = o_rsp_fault;
    rsp_err_d   = o_rsp_err;
    validcmd_d  = 1'b0;
    cmd_d       = o_mmu_cmd;
    oaddr_d     = o_addr;
    wrdata_d    = o_wrdata;
    osize_d     = o_size;
`ifdef SWIVM_MEMSEQ_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The ready pulse is shown while still in IDLE; leave on the following edge.
        if (|o_req_ready) begin
          state_d = ST_ISSUE;
        end else if (|i_req_valid) begin
          arb_en_c = 1'b1;
          ready_d  = arb_grant_c;
          ch_d     = arb_idx_c;
          write_d  = i_req_write[arb_idx_c];
          signed_d = i_req_signed[arb_idx_c];
          size_d   = i_req_size[int'(arb_idx_c)*2 +: 2];
          addr_d   = i_req_addr[int'(arb_idx_c)*ADDR_W +: ADDR_W];
          wdata_d  = i_req_wdata[int'(arb_idx_c)*DATA_W +: DATA_W];
        end
      end
      ST_ISSUE: begin
        if (is_misaligned(size_q, addr_q[1:0])) begin
          pend_d.fault = 1'b1;
          pend_d.err   = ERR_MISALIGN;
          pend_data_d  = '0;
          state_d      = ST_RESP;
        end else begin
          validcmd_d = 1'b1;
          cmd_d      = write_q ? MMU_WRITE : MMU_READ;
          oaddr_d    = addr_q;
          wrdata_d   = wdata_q;
          osize_d    = size_q;
          state_d    = ST_WAIT;
`ifdef SWIVM_MEMSEQ_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (i_rddata_valid) begin
          state_d = ST_RESP;
          if (i_mmu_error != ERR_NONE) begin
            pend_d.fault = 1'b1;
            pend_d.err   = i_mmu_error;
            pend_data_d  = '0;
          end else begin
            pend_d.fault = 1'b0;
            pend_d.err   = ERR_NONE;
            pend_data_d  = write_q ? '0 : extend(i_rddata, size_q, signed_q);
          end
        end
`ifdef SWIVM_MEMSEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = ST_RESP;
          pend_d.fault = 1'b1;
          pend_d.err   = ERR_TIMEOUT;
          pend_data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid_d = NREQ'(1) << ch_q;
        rsp_data_d  = pend_data_q;
        rsp_fault_d = pend_q.fault;
        rsp_err_d   = pend_q.err;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ch_q           <= '0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      pend_data_q    <= '0;
      pend_q         <= '0;
      o_req_ready    <= '0;
      o_rsp_valid    <= '0;
      o_rsp_data     <= '0;
      o_rsp_fault    <= 1'b0;
      o_rsp_err      <= '0;
      o_mmu_validcmd <= 1'b0;
      o_mmu_cmd      <= '0;
      o_addr         <= '0;
      o_wrdata       <= '0;
      o_size         <= '0;
    end else begin
      ch_q           <= ch_d;
      write_q        <= write_d;
      signed_q       <= signed_d;
      size_q         <= size_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      pend_data_q    <= pend_data_d;
      pend_q         <= pend_d;
      o_req_ready    <= ready_d;
      o_rsp_valid    <= rsp_valid_d;
      o_rsp_data     <= rsp_data_d;
      o_rsp_fault    <= rsp_fault_d;
      o_rsp_err      <= rsp_err_d;
      o_mmu_validcmd <= validcmd_d;
      o_mmu_cmd      <= cmd_d;
      o_addr         <= oaddr_d;
      o_wrdata       <= wrdata_d;
      o_size         <= osize_d;
    end
  end

`ifdef SWIVM_MEMSEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_swivm_memseq.sv
// Self-checking bench for swivm_memseq: directed cases plus random accesses against a reference model.
// Define SWIVM_MEMSEQ_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_swivm_memseq;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic                   i_clk = 1'b0;
  logic                   i_reset;
  logic [NREQ-1:0]        i_req_valid, i_req_write, i_req_signed;
  logic [2*NREQ-1:0]      i_req_size;
  logic [ADDR_W*NREQ-1:0] i_req_addr;
  logic [DATA_W*NREQ-1:0] i_req_wdata;
  logic [NREQ-1:0]        o_req_ready, o_rsp_valid;
  logic [DATA_W-1:0]      o_rsp_data, o_wrdata, i_rddata;
  logic                   o_rsp_fault, o_mmu_validcmd, i_rddata_valid;
  logic [3:0]             o_rsp_err, o_mmu_cmd, i_mmu_error;
  logic [ADDR_W-1:0]      o_addr;
  logic [1:0]             o_size;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // MMU model controls (main process) and observations (monitor process).
  logic [31:0] mmu_data;
  logic [3:0]  mmu_err;
  int          mmu_delay;
  bit          mmu_silent;
  int          stray_req = 0;
  int          stray_done;
  int          cmd_cnt = 0;
  logic [3:0]  seen_cmd;
  logic [31:0] seen_addr, seen_wrdata;
  logic [1:0]  seen_size;
  int          model_last;

  swivm_memseq #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_req_signed(i_req_signed),
    .i_req_size(i_req_size), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_rsp_fault(o_rsp_fault), .o_rsp_err(o_rsp_err),
    .o_addr(o_addr), .o_wrdata(o_wrdata), .o_size(o_size), .o_mmu_cmd(o_mmu_cmd),
    .o_mmu_validcmd(o_mmu_validcmd),
    .i_rddata(i_rddata), .i_rddata_valid(i_rddata_valid), .i_mmu_error(i_mmu_error)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference rules, written directly from the access semantics.
  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'b01) || (sz == 2'b10 && addr % 2 != 0) || (sz == 2'b11 && addr % 4 != 0);
  endfunction

  function automatic logic [36:0] ref_rsp(input logic wr, input logic sgn, input logic [1:0] sz,
                                          input logic [31:0] addr, input logic [31:0] md,
                                          input logic [3:0] me);
    logic [31:0] d;
    if (ref_misaligned(sz, addr)) return {1'b1, 4'hE, 32'h0};
    if (me != 4'h0) return {1'b1, me, 32'h0};
    if (wr) return {1'b0, 4'h0, 32'h0};
    d = md;
    if (sz == 2'b00) begin
      d = md % 256;
      if (sgn && d >= 128) d = d - 32'd256;
    end else if (sz == 2'b10) begin
      d = md % 65536;
      if (sgn && d >= 32768) d = d - 32'd65536;
    end
    return {1'b0, 4'h0, d};
  endfunction

  function automatic int ref_next(input int last, input logic [NREQ-1:0] mask);
    int c;
    for (int i = 1; i <= int'(NREQ); i++) begin
      c = (last + i) % int'(NREQ);
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor of the MMU command port.
  initial forever begin
    @(negedge i_clk);
    if (o_mmu_validcmd === 1'b1) begin
      cmd_cnt++;
      seen_cmd    = o_mmu_cmd;
      seen_addr   = o_addr;
      seen_size   = o_size;
      seen_wrdata = o_wrdata;
    end
  end

  // MMU responder: answers a command after mmu_delay cycles, or injects a stray completion.
  initial begin
    i_rddata_valid = 1'b0;
    i_rddata       = '0;
    i_mmu_error    = '0;
    stray_done     = 0;
    forever begin
      @(negedge i_clk);
      if (stray_req != stray_done) begin
        stray_done     = stray_req;
        i_rddata       = 32'hA5A5A5A5;
        i_rddata_valid = 1'b1;
        @(negedge i_clk);
        i_rddata_valid = 1'b0;
      end else if (o_mmu_validcmd === 1'b1 && !mmu_silent) begin
        repeat (mmu_delay) @(negedge i_clk);
        i_rddata       = mmu_data;
        i_mmu_error    = mmu_err;
        i_rddata_valid = 1'b1;
        @(negedge i_clk);
        i_rddata_valid = 1'b0;
        i_mmu_error    = '0;
        i_rddata       = $urandom;
      end
    end
  end

  task automatic wait_ready(output int got);
    got = -1;
    for (int k = 0; k < 20; k++) begin
      if (|o_req_ready) break;
      @(negedge i_clk);
    end
    for (int c = 0; c < int'(NREQ); c++) if (o_req_ready[c]) got = c;
  endtask

  task automatic wait_rsp(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (|o_rsp_valid) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    check({tag, ".rsp_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic quiet_window(input string tag, input int n);
    int pulses = 0;
    repeat (n) begin
      @(negedge i_clk);
      if (|o_rsp_valid) pulses++;
    end
    check({tag, ".no_rsp"}, 64'(pulses), 64'd0);
  endtask

  task automatic run_txn(input string tag, input int ch, input logic wr, input logic sgn,
                         input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] md, input logic [3:0] me, input int dly, input bit silent);
    logic [36:0] exp;
    bit bad;
    int got, c0, cmd0, exp_lat;
    bad = ref_misaligned(sz, addr);
    exp = ref_rsp(wr, sgn, sz, addr, md, me);
    if (silent && !bad) exp = {1'b1, 4'hF, 32'h0};
    exp_lat = bad ? 3 : (silent ? 3 + int'(TIMEOUT) : 4 + dly);
    mmu_data = md; mmu_err = me; mmu_delay = dly; mmu_silent = silent;
    cmd0 = cmd_cnt;
    i_req_write[ch]          = wr;
    i_req_signed[ch]         = sgn;
    i_req_size[ch*2 +: 2]    = sz;
    i_req_addr[ch*32 +: 32]  = addr;
    i_req_wdata[ch*32 +: 32] = wdata;
    i_req_valid              = '0;
    i_req_valid[ch]          = 1'b1;
    wait_ready(got);
    check({tag, ".grant"}, 64'(got), 64'(ch));
    c0 = cyc;
    model_last = ch;
    i_req_valid = '0;
    @(negedge i_clk);
    check({tag, ".holdoff"}, 64'(o_req_ready), 64'd0);
    wait_rsp(tag);
    check({tag, ".latency"}, 64'(cyc - c0), 64'(exp_lat));
    check({tag, ".rsp_valid"}, 64'(o_rsp_valid), 64'(1 << ch));
    check({tag, ".data"}, 64'(o_rsp_data), 64'(exp[31:0]));
    check({tag, ".fault"}, 64'(o_rsp_fault), 64'(exp[36]));
    check({tag, ".err"}, 64'(o_rsp_err), 64'(exp[35:32]));
    @(negedge i_clk);
    check({tag, ".rsp_pulse"}, 64'(o_rsp_valid), 64'd0);
    check({tag, ".data_hold"}, 64'(o_rsp_data), 64'(exp[31:0]));
    check({tag, ".cmd_count"}, 64'(cmd_cnt - cmd0), bad ? 64'd0 : 64'd1);
    if (!bad) begin
      check({tag, ".mmu_cmd"}, 64'(seen_cmd), wr ? 64'h2 : 64'h1);
      check({tag, ".mmu_addr"}, 64'(seen_addr), 64'(addr));
      check({tag, ".mmu_size"}, 64'(seen_size), 64'(sz));
      if (wr) check({tag, ".mmu_wrdata"}, 64'(seen_wrdata), 64'(wdata));
    end
  endtask

  // Every channel in vmask requests word reads continuously for n transactions.
  task automatic run_rr(input string tag, input int n, input logic [NREQ-1:0] vmask);
    int got, exp_g;
    mmu_silent = 1'b0; mmu_delay = 0; mmu_err = 4'h0;
    for (int c = 0; c < int'(NREQ); c++) begin
      i_req_write[c]          = 1'b0;
      i_req_signed[c]         = 1'b0;
      i_req_size[c*2 +: 2]    = 2'b11;
      i_req_addr[c*32 +: 32]  = 32'h200 + 32'(c) * 32'h10;
      i_req_wdata[c*32 +: 32] = '0;
    end
    i_req_valid = vmask;
    for (int t = 0; t < n; t++) begin
      exp_g = ref_next(model_last, vmask);
      mmu_data = 32'hC0DE0000 + 32'(t);
      wait_ready(got);
      check($sformatf("%s.grant%0d", tag, t), 64'(got), 64'(exp_g));
      model_last = exp_g;
      @(negedge i_clk);
      wait_rsp(tag);
      check($sformatf("%s.rsp_valid%0d", tag, t), 64'(o_rsp_valid), 64'(1 << exp_g));
      check($sformatf("%s.data%0d", tag, t), 64'(o_rsp_data), 64'(32'hC0DE0000 + 32'(t)));
    end
    i_req_valid = '0;
    @(negedge i_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int ch;
    logic wr, sgn;
    logic [1:0] sz;
    logic [31:0] addr;
    logic [3:0] me;
    int r;

    i_reset = 1'b1;
    i_req_valid = '0; i_req_write = '0; i_req_signed = '0;
    i_req_size = '0; i_req_addr = '0; i_req_wdata = '0;
    mmu_data = '0; mmu_err = '0; mmu_delay = 0; mmu_silent = 1'b0;
    model_last = NREQ - 1;
    repeat (3) @(negedge i_clk);
    check("reset.ready", 64'(o_req_ready), 64'd0);
    check("reset.rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("reset.rsp_data", 64'(o_rsp_data), 64'd0);
    check("reset.rsp_flags", 64'({o_rsp_fault, o_rsp_err}), 64'd0);
    check("reset.mmu", 64'({o_mmu_validcmd, o_mmu_cmd, o_size}), 64'd0);
    check("reset.addr", 64'(o_addr), 64'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    run_txn("word_rd", 0, 1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 32'hDEADBEEF, 4'h0, 0, 1'b0);
    run_txn("sbyte_rd", 1, 1'b0, 1'b1, 2'b00, 32'h203, 32'h0, 32'h00000080, 4'h0, 0, 1'b0);
    run_txn("ubyte_rd", 1, 1'b0, 1'b0, 2'b00, 32'h203, 32'h0, 32'h00000080, 4'h0, 1, 1'b0);
    run_txn("shalf_rd", 0, 1'b0, 1'b1, 2'b10, 32'h302, 32'h0, 32'h1234F00D, 4'h0, 2, 1'b0);
    run_txn("misalign", 0, 1'b0, 1'b0, 2'b11, 32'h102, 32'h0, 32'h11111111, 4'h0, 0, 1'b0);
    run_txn("size01", 1, 1'b0, 1'b0, 2'b01, 32'h100, 32'h0, 32'h11111111, 4'h0, 0, 1'b0);
    run_txn("mmu_err", 1, 1'b0, 1'b0, 2'b11, 32'h400, 32'h0, 32'hCAFEF00D, 4'h3, 0, 1'b0);
    run_txn("write", 0, 1'b1, 1'b0, 2'b11, 32'h500, 32'h89ABCDEF, 32'h5555AAAA, 4'h0, 1, 1'b0);
    run_txn("word_rd2", 1, 1'b0, 1'b0, 2'b11, 32'h600, 32'h0, 32'h76543210, 4'h0, 0, 1'b0);

    stray_req++;
    quiet_window("stray_idle", 6);

    // Abort an access in WAIT; response data from the previous access is nonzero here.
    mmu_silent = 1'b1;
    i_req_write[0] = 1'b0; i_req_size[1:0] = 2'b11; i_req_addr[31:0] = 32'h700;
    i_req_valid = 2'b01;
    wait_ready(ch);
    check("abort.grant", 64'(ch), 64'd0);
    i_req_valid = '0;
    for (int k = 0; k < 10 && o_mmu_validcmd !== 1'b1; k++) @(negedge i_clk);
    check("abort.cmd_issued", 64'(o_mmu_validcmd), 64'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("abort.addr_clr", 64'(o_addr), 64'd0);
    check("abort.rsp_data_clr", 64'(o_rsp_data), 64'd0);
    check("abort.cmd_clr", 64'({o_mmu_validcmd, o_mmu_cmd}), 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    model_last = NREQ - 1;
    mmu_silent = 1'b0;
    quiet_window("abort", 10);
    run_rr("rr", 4, 2'b11);

    for (int t = 0; t < 24; t++) begin
      ch  = $urandom_range(0, NREQ - 1);
      wr  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 9);
      sz  = (r < 3) ? 2'b00 : (r < 6) ? 2'b10 : (r < 9) ? 2'b11 : 2'b01;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % ((sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1));
      me = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 13)) : 4'h0;
      run_txn($sformatf("rand%0d", t), ch, wr, sgn, sz, addr, $urandom, $urandom, me,
              $urandom_range(0, 3), 1'b0);
    end

`ifdef SWIVM_MEMSEQ_TIMEOUT_EN
    run_txn("timeout", 1, 1'b0, 1'b0, 2'b11, 32'h800, 32'h0, 32'h0, 4'h0, 0, 1'b1);
    mmu_silent = 1'b0;
    stray_req++;
    quiet_window("late_valid", 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
